fust_scoreboard: RTL and testbench



---
 rtl/datapath_pkg.sv | 41 ++++
 rtl/rr_picker.sv | 30 +++
 rtl/fust_scoreboard.sv | 135 +++++++++++++
 tb/tb_fust_scoreboard.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared issue-stage types: FU status entry, register result status and width helpers.
// Struct field widths come from the DP_* configuration below.
package datapath_pkg;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DP_N_FU   = 4;
    localparam int DP_N_REGS = 32;
    localparam int DP_OP_W   = 8;
    localparam int DP_N_WB   = 2;
    localparam int DP_FU_W   = clog2_min1(DP_N_FU);
    localparam int DP_REG_W  = clog2_min1(DP_N_REGS);

    typedef enum logic [1:0] {
        ST_FREE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_READY  = 2'd2,
        ST_ISSUED = 2'd3
    } fust_state_e;

    typedef struct packed {
        fust_state_e          state;
        logic [DP_OP_W-1:0]   op;
        logic [DP_REG_W-1:0]  rd;
        logic                 rd_en;
        logic [DP_REG_W-1:0]  rs1;
        logic [DP_REG_W-1:0]  rs2;
        logic [DP_FU_W-1:0]   qj;
        logic [DP_FU_W-1:0]   qk;
        logic                 rj;
        logic                 rk;
    } fust_entry_t;

    typedef struct packed {
        logic                valid;
        logic [DP_FU_W-1:0]  fu;
    } rstat_t;

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first request at or after ptr, wrapping, as one-hot grant plus index.
module rr_picker #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [W-1:0] idx,
    output logic         any
);
    logic found;
    int   j;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int i = 0; i < N; i++) begin
            j = (int'(ptr) + i) % N;
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = W'(j);
            end
        end
        any = found;
    end
endmodule

// File: rtl/fust_scoreboard.sv
// Function-unit status table with register result status: tracks RAW/WAW hazards,
// wakes waiting entries on writeback and issues one ready entry per cycle round-robin.
module fust_scoreboard
    import datapath_pkg::*;
#(
    parameter int N_FU   = DP_N_FU,
    parameter int N_REGS = DP_N_REGS,
    parameter int OP_W   = DP_OP_W,
    parameter int N_WB   = DP_N_WB,
    parameter int FU_W   = clog2_min1(N_FU),
    parameter int REG_W  = clog2_min1(N_REGS)
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      flush,
    input  logic                      freeze,
    input  logic                      disp_valid,
    output logic                      disp_ready,
    input  logic [FU_W-1:0]           disp_fu,
    input  logic [OP_W-1:0]           disp_op,
    input  logic [REG_W-1:0]          disp_rd,
    input  logic [REG_W-1:0]          disp_rs1,
    input  logic [REG_W-1:0]          disp_rs2,
    input  logic                      disp_rd_en,
    input  logic [N_WB-1:0]           wb_valid,
    input  logic [N_WB-1:0][FU_W-1:0] wb_fu,
    output logic                      iss_valid,
    input  logic                      iss_ready,
    output logic [FU_W-1:0]           iss_fu,
    output logic [OP_W-1:0]           iss_op,
    output logic [REG_W-1:0]          iss_rd,
    output logic [REG_W-1:0]          iss_rs1,
    output logic [REG_W-1:0]          iss_rs2,
    output logic [N_FU-1:0]           fu_busy
);
    fust_entry_t     ent   [N_FU];
    fust_entry_t     ent_n [N_FU];
    rstat_t          rstat   [N_REGS];
    rstat_t          rstat_n [N_REGS];
    logic [FU_W-1:0] rr_ptr, sel;
    logic [N_FU-1:0] req, grant, done, kill;
    logic            any_ready, disp_fire, iss_fire, rs1_ok, rs2_ok;

    // Writebacks only complete entries that were actually issued.
    always_comb begin
        for (int k = 0; k < N_FU; k++) begin
            done[k] = 1'b0;
            for (int i = 0; i < N_WB; i++)
                if (wb_valid[i] && wb_fu[i] == FU_W'(k)) done[k] = 1'b1;
            done[k]    = done[k] && (ent[k].state == ST_ISSUED);
            kill[k]    = flush && (ent[k].state == ST_WAIT || ent[k].state == ST_READY);
            req[k]     = (ent[k].state == ST_READY);
            fu_busy[k] = (ent[k].state != ST_FREE);
        end
    end

    rr_picker #(.N(N_FU), .W(FU_W)) u_pick (
        .req   (req),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (sel),
        .any   (any_ready)
    );

    assign disp_ready = !RST && !freeze && !flush && (ent[disp_fu].state == ST_FREE)
                        && !(disp_rd_en && rstat[disp_rd].valid);
    assign disp_fire  = disp_valid && disp_ready;
    assign iss_valid  = any_ready && !freeze && !flush;
    assign iss_fire   = iss_valid && iss_ready;
    // A source owned by an FU completing this cycle is bypassed as ready.
    assign rs1_ok     = !rstat[disp_rs1].valid || done[rstat[disp_rs1].fu];
    assign rs2_ok     = !rstat[disp_rs2].valid || done[rstat[disp_rs2].fu];

    always_comb begin
        ent_n   = ent;
        rstat_n = rstat;
        for (int k = 0; k < N_FU; k++) begin
            if ((done[k] || kill[k]) && ent[k].rd_en && rstat[ent[k].rd].valid
                && rstat[ent[k].rd].fu == FU_W'(k))
                rstat_n[ent[k].rd].valid = 1'b0;
            if (done[k] || kill[k]) begin
                ent_n[k].state = ST_FREE;
            end else begin
                if (!ent[k].rj && done[ent[k].qj]) ent_n[k].rj = 1'b1;
                if (!ent[k].rk && done[ent[k].qk]) ent_n[k].rk = 1'b1;
                if (ent[k].state == ST_WAIT && ent_n[k].rj && ent_n[k].rk)
                    ent_n[k].state = ST_READY;
                if (iss_fire && grant[k]) ent_n[k].state = ST_ISSUED;
            end
        end
        if (disp_fire) begin
            ent_n[disp_fu].state = (rs1_ok && rs2_ok) ? ST_READY : ST_WAIT;
            ent_n[disp_fu].op    = disp_op;
            ent_n[disp_fu].rd    = disp_rd;
            ent_n[disp_fu].rd_en = disp_rd_en;
            ent_n[disp_fu].rs1   = disp_rs1;
            ent_n[disp_fu].rs2   = disp_rs2;
            ent_n[disp_fu].qj    = rstat[disp_rs1].fu;
            ent_n[disp_fu].qk    = rstat[disp_rs2].fu;
            ent_n[disp_fu].rj    = rs1_ok;
            ent_n[disp_fu].rk    = rs2_ok;
            if (disp_rd_en && disp_rd != '0) begin
                rstat_n[disp_rd].valid = 1'b1;
                rstat_n[disp_rd].fu    = disp_fu;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int k = 0; k < N_FU; k++) ent[k] <= '0;
            for (int r = 0; r < N_REGS; r++) rstat[r] <= '0;
            rr_ptr <= '0;
        end else begin
            ent   <= ent_n;
            rstat <= rstat_n;
            if (iss_fire) rr_ptr <= (sel == FU_W'(N_FU - 1)) ? '0 : sel + 1'b1;
        end
    end

    always_comb begin
        iss_fu  = '0;
        iss_op  = '0;
        iss_rd  = '0;
        iss_rs1 = '0;
        iss_rs2 = '0;
        if (iss_valid) begin
            iss_fu  = sel;
            iss_op  = ent[sel].op;
            iss_rd  = ent[sel].rd;
            iss_rs1 = ent[sel].rs1;
            iss_rs2 = ent[sel].rs2;
        end
    end
endmodule

// File: tb/tb_fust_scoreboard.sv
// Randomized bench for fust_scoreboard: a per-cycle reference model predicts issue packets
// into a queue that an independent monitor drains against the DUT's issue handshakes.
module tb_fust_scoreboard;
    localparam int N_FU = 4, N_REGS = 32, OP_W = 8, N_WB = 2, FU_W = 2, REG_W = 5;
    localparam int M_FREE = 0, M_WAIT = 1, M_READY = 2, M_ISS = 3;

    logic                      CLK, RST, flush, freeze, disp_valid, disp_ready, disp_rd_en;
    logic [FU_W-1:0]           disp_fu, iss_fu;
    logic [OP_W-1:0]           disp_op, iss_op;
    logic [REG_W-1:0]          disp_rd, disp_rs1, disp_rs2, iss_rd, iss_rs1, iss_rs2;
    logic [N_WB-1:0]           wb_valid;
    logic [N_WB-1:0][FU_W-1:0] wb_fu;
    logic                      iss_valid, iss_ready;
    logic [N_FU-1:0]           fu_busy;

    fust_scoreboard dut (
        .CLK(CLK), .RST(RST), .flush(flush), .freeze(freeze),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_fu(disp_fu), .disp_op(disp_op),
        .disp_rd(disp_rd), .disp_rs1(disp_rs1), .disp_rs2(disp_rs2), .disp_rd_en(disp_rd_en),
        .wb_valid(wb_valid), .wb_fu(wb_fu),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_fu(iss_fu), .iss_op(iss_op),
        .iss_rd(iss_rd), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .fu_busy(fu_busy)
    );

    typedef struct { int fu; int op; int rd; int rs1; int rs2; } pkt_t;
    pkt_t exp_q[$];
    int checks = 0, errors = 0;

    // Reference model: per-FU status, outstanding producers (-1 = operand available),
    // and the FU that owns each register's pending result (-1 = none).
    int m_st[N_FU], m_op[N_FU], m_rd[N_FU], m_rs1[N_FU], m_rs2[N_FU], m_q1[N_FU], m_q2[N_FU];
    bit m_rden[N_FU];
    int m_owner[N_REGS];
    int m_rr;

    initial begin
        CLK = 0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < N_FU; k++) begin
            m_st[k] = M_FREE; m_q1[k] = -1; m_q2[k] = -1; m_rden[k] = 0;
            m_op[k] = 0; m_rd[k] = 0; m_rs1[k] = 0; m_rs2[k] = 0;
        end
        for (int r = 0; r < N_REGS; r++) m_owner[r] = -1;
        m_rr = 0;
    endfunction

    task automatic model_step();
        int old_st[N_FU];
        bit done[N_FU];
        bit exp_dr, exp_iv;
        int sel, busy, f, o1, o2;
        exp_dr = !freeze && !flush && m_st[disp_fu] == M_FREE
                 && !(disp_rd_en && m_owner[disp_rd] >= 0);
        sel = -1;
        for (int i = 0; i < N_FU; i++)
            if (sel < 0 && m_st[(m_rr + i) % N_FU] == M_READY) sel = (m_rr + i) % N_FU;
        exp_iv = (sel >= 0) && !freeze && !flush;
        busy = 0;
        for (int k = 0; k < N_FU; k++) if (m_st[k] != M_FREE) busy |= (1 << k);
        chk("disp_ready", int'(disp_ready), int'(exp_dr));
        chk("iss_valid", int'(iss_valid), int'(exp_iv));
        chk("fu_busy", int'(fu_busy), busy);

        for (int k = 0; k < N_FU; k++) begin
            old_st[k] = m_st[k];
            done[k] = 0;
            for (int p = 0; p < N_WB; p++)
                if (wb_valid[p] && int'(wb_fu[p]) == k && m_st[k] == M_ISS) done[k] = 1;
        end
        o1 = m_owner[disp_rs1];
        o2 = m_owner[disp_rs2];
        if (o1 >= 0 && done[o1]) o1 = -1;
        if (o2 >= 0 && done[o2]) o2 = -1;

        if (exp_iv && iss_ready) begin
            exp_q.push_back('{sel, m_op[sel], m_rd[sel], m_rs1[sel], m_rs2[sel]});
            m_st[sel] = M_ISS;
            m_rr = (sel + 1) % N_FU;
        end
        for (int k = 0; k < N_FU; k++) begin
            if (done[k] || (flush && (old_st[k] == M_WAIT || old_st[k] == M_READY))) begin
                m_st[k] = M_FREE;
                if (m_rden[k] && m_owner[m_rd[k]] == k) m_owner[m_rd[k]] = -1;
            end
            if (done[k])
                for (int e = 0; e < N_FU; e++) begin
                    if (m_q1[e] == k) m_q1[e] = -1;
                    if (m_q2[e] == k) m_q2[e] = -1;
                end
        end
        for (int k = 0; k < N_FU; k++)
            if (m_st[k] == M_WAIT && m_q1[k] < 0 && m_q2[k] < 0) m_st[k] = M_READY;
        if (disp_valid && exp_dr) begin
            f = int'(disp_fu);
            m_op[f] = int'(disp_op); m_rd[f] = int'(disp_rd); m_rden[f] = disp_rd_en;
            m_rs1[f] = int'(disp_rs1); m_rs2[f] = int'(disp_rs2);
            m_q1[f] = o1; m_q2[f] = o2;
            m_st[f] = (o1 < 0 && o2 < 0) ? M_READY : M_WAIT;
            if (disp_rd_en && disp_rd != 0) m_owner[disp_rd] = f;
        end
    endtask

    always @(negedge CLK) begin
        if (RST) begin
            chk("rst_disp_ready", int'(disp_ready), 0);
            chk("rst_iss_valid", int'(iss_valid), 0);
            chk("rst_fu_busy", int'(fu_busy), 0);
            chk("rst_iss_rd", int'(iss_rd), 0);
            model_reset();
        end else begin
            model_step();
        end
    end

    // Monitor: every DUT issue handshake must match the oldest predicted packet.
    always @(negedge CLK) begin
        pkt_t p;
        #1;
        if (!RST && iss_valid && iss_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL issue_unexpected got fu=%0d rd=%0d", iss_fu, iss_rd);
            end else begin
                p = exp_q.pop_front();
                if (int'(iss_fu) != p.fu || int'(iss_op) != p.op || int'(iss_rd) != p.rd
                    || int'(iss_rs1) != p.rs1 || int'(iss_rs2) != p.rs2) begin
                    errors++;
                    $display("FAIL issue_pkt got fu=%0d op=%0d rd=%0d rs1=%0d rs2=%0d exp fu=%0d op=%0d rd=%0d rs1=%0d rs2=%0d",
                             iss_fu, iss_op, iss_rd, iss_rs1, iss_rs2, p.fu, p.op, p.rd, p.rs1, p.rs2);
                end
            end
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL issue_missing got none exp fu=%0d", exp_q[0].fu);
            exp_q.delete();
        end
    end

    task automatic drive_random();
        int iss_list[$];
        flush      = ($urandom_range(0, 99) < 3);
        freeze     = ($urandom_range(0, 99) < 8);
        iss_ready  = ($urandom_range(0, 99) < 75);
        disp_valid = ($urandom_range(0, 99) < 60);
        disp_fu    = FU_W'($urandom_range(0, N_FU - 1));
        disp_op    = OP_W'($urandom);
        disp_rd    = REG_W'($urandom_range(0, 7));
        disp_rs1   = REG_W'($urandom_range(0, 7));
        disp_rs2   = REG_W'($urandom_range(0, 7));
        disp_rd_en = ($urandom_range(0, 99) < 80);
        for (int k = 0; k < N_FU; k++) if (m_st[k] == M_ISS) iss_list.push_back(k);
        for (int p = 0; p < N_WB; p++) begin
            wb_valid[p] = ($urandom_range(0, 99) < 40);
            if (iss_list.size() > 0 && $urandom_range(0, 99) < 80)
                wb_fu[p] = FU_W'(iss_list[$urandom_range(0, iss_list.size() - 1)]);
            else
                wb_fu[p] = FU_W'($urandom_range(0, N_FU - 1));
        end
    endtask

    initial begin
        RST = 1;
        model_reset();
        drive_random();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge CLK);
            #1;
            RST = (cyc < 3) || (cyc >= 2000 && cyc < 2003);
            drive_random();
        end
        @(posedge CLK);
        #1;
        RST = 1;
        repeat (2) @(posedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
